// File: rtl/cpc_exp_mailbox.sv
// cpc_exp_mailbox: Z80 expansion-port byte mailbox with TX/RX FIFOs, status/control and level IRQ.
// Optional feature macro: CPC_EXP_MAILBOX_IM2_EN (offset 3 VECTOR register, IM2 acknowledge).
module cpc_exp_mailbox #(
  parameter logic [15:0] BASE_ADDR  = 16'hFBD0,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            r_tx_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp;
  logic [DEPTH_LOG2:0]   r_tx_cnt;
  logic [7:0]            r_rx_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_rx_wp, r_rx_rp;
  logic [DEPTH_LOG2:0]   r_rx_cnt;

  logic       r_served, r_pop_pend, r_stat_rd;
  logic       r_rx_unf, r_tx_ovf, r_rx_ie, r_tx_ie, r_irq;
  logic [7:0] r_stat;

  logic       w_hit, w_acc, w_start, w_end, w_wr_start, w_rd_start;
  logic [1:0] w_off;
  logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic       w_flush, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [7:0] w_status_live, w_din;
  logic       w_unused_ok;

  assign w_hit      = (cpu_addr[15:2] == BASE_ADDR[15:2]);
  assign w_acc      = iorq & ~m1 & (rd | wr) & w_hit;
  assign w_start    = w_acc & ~r_served;
  assign w_end      = r_served & ~iorq;
  assign w_wr_start = w_start & wr;
  assign w_rd_start = w_start & rd;
  assign w_off      = cpu_addr[1:0];

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);

  assign w_status_live = {r_irq, 2'b00, r_tx_ovf, w_tx_empty, r_rx_unf, ~w_tx_full, ~w_rx_empty};

  // Flush has priority over every push/pop in the same clk.
  assign w_flush   = w_wr_start & (w_off == 2'd2) & cpu_dout[7];
  assign w_tx_push = w_wr_start & (w_off == 2'd0) & ~w_tx_full & ~w_flush;
  assign w_tx_pop  = tx_valid & tx_ready & ~w_flush;
  assign w_rx_push = rx_valid & rx_ready & ~w_flush;
  assign w_rx_pop  = w_end & r_pop_pend & ~w_flush;

  assign tx_data  = r_tx_mem[r_tx_rp];
  assign tx_valid = ~w_tx_empty;
  assign rx_ready = ~w_rx_full;
  assign irq      = r_irq;

  assign w_unused_ok = ^cpu_dout[6:2];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= cpu_dout;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else if (w_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else if (w_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  // Per-cycle bookkeeping: what the end event must do is decided at the start event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_served   <= 1'b0;
      r_pop_pend <= 1'b0;
      r_stat_rd  <= 1'b0;
      r_stat     <= 8'h00;
    end else begin
      if (!iorq)      r_served <= 1'b0;
      else if (w_acc) r_served <= 1'b1;

      if (w_rd_start && w_off == 2'd0) r_pop_pend <= ~w_rx_empty;
      else if (w_end)                  r_pop_pend <= 1'b0;

      if (w_rd_start && w_off == 2'd1) r_stat_rd <= 1'b1;
      else if (w_end)                  r_stat_rd <= 1'b0;

      if (w_start) r_stat <= w_status_live;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_unf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_rx_ie  <= 1'b0;
      r_tx_ie  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_rd_start && w_off == 2'd0 && w_rx_empty) r_rx_unf <= 1'b1;
      else if (w_end && r_stat_rd)                   r_rx_unf <= 1'b0;

      if (w_wr_start && w_off == 2'd0 && w_tx_full) r_tx_ovf <= 1'b1;
      else if (w_end && r_stat_rd)                  r_tx_ovf <= 1'b0;

      if (w_wr_start && w_off == 2'd2) begin
        r_rx_ie <= cpu_dout[0];
        r_tx_ie <= cpu_dout[1];
      end

      r_irq <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty);
    end
  end

`ifdef CPC_EXP_MAILBOX_IM2_EN
  logic [7:0] r_vector;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_vector <= 8'hFF;
    else if (w_wr_start && w_off == 2'd3) r_vector <= cpu_dout;
  end
`endif

  always_comb begin
    w_din = 8'hFF;
    if (w_acc && rd) begin
      unique case (w_off)
        2'd0: if (r_served ? r_pop_pend : ~w_rx_empty) w_din = r_rx_mem[r_rx_rp];
        2'd1: w_din = r_served ? r_stat : w_status_live;
        2'd2: w_din = {6'b000000, r_tx_ie, r_rx_ie};
`ifdef CPC_EXP_MAILBOX_IM2_EN
        2'd3: w_din = r_vector;
`else
        2'd3: w_din = 8'hFF;
`endif
        default: w_din = 8'hFF;
      endcase
    end
`ifdef CPC_EXP_MAILBOX_IM2_EN
    if (m1 && iorq && r_irq) w_din = r_vector;
`endif
  end

  assign cpu_din = w_din;

endmodule

// File: tb/tb_cpc_exp_mailbox.sv
// Self-checking bench for cpc_exp_mailbox: directed scenarios plus a randomized run against a
// queue-based model of the mailbox. Honours CPC_EXP_MAILBOX_IM2_EN when defined.
module tb_cpc_exp_mailbox;

  localparam logic [15:0] BASE = 16'hFBD0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        iorq, rd, wr, m1;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_rx_unf, m_tx_ovf, m_rx_ie, m_tx_ie;
  logic [7:0] m_vec;

  cpc_exp_mailbox #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .iorq     (iorq),
    .rd       (rd),
    .wr       (wr),
    .m1       (m1),
    .irq      (irq),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  function automatic void m_reset();
    tx_q.delete();
    rx_q.delete();
    m_rx_unf = 1'b0;
    m_tx_ovf = 1'b0;
    m_rx_ie  = 1'b0;
    m_tx_ie  = 1'b0;
    m_vec    = 8'hFF;
  endfunction

  function automatic logic m_irq();
    return (m_rx_ie && rx_q.size() != 0) || (m_tx_ie && tx_q.size() == 0);
  endfunction

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (rx_q.size() != 0);
    s[1] = (tx_q.size() < 16);
    s[2] = m_rx_unf;
    s[3] = (tx_q.size() == 0);
    s[4] = m_tx_ovf;
    s[7] = m_irq();
    return s;
  endfunction

  // Expected read data for an I/O read at offset off, with its side effects.
  function automatic logic [7:0] m_read(input logic [1:0] off);
    logic [7:0] r;
    r = 8'hFF;
    case (off)
      2'd0: begin
        if (rx_q.size() == 0) m_rx_unf = 1'b1;
        else                  r = rx_q.pop_front();
      end
      2'd1: begin
        r = m_status();
        m_rx_unf = 1'b0;
        m_tx_ovf = 1'b0;
      end
      2'd2: r = {6'b000000, m_tx_ie, m_rx_ie};
`ifdef CPC_EXP_MAILBOX_IM2_EN
      2'd3: r = m_vec;
`endif
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  function automatic void m_write(input logic [1:0] off, input logic [7:0] d);
    case (off)
      2'd0: begin
        if (tx_q.size() < 16) tx_q.push_back(d);
        else                  m_tx_ovf = 1'b1;
      end
      2'd2: begin
        m_rx_ie = d[0];
        m_tx_ie = d[1];
        if (d[7]) begin
          tx_q.delete();
          rx_q.delete();
        end
      end
`ifdef CPC_EXP_MAILBOX_IM2_EN
      2'd3: m_vec = d;
`endif
      default: ;
    endcase
  endfunction

  // Bus tasks: d1 sampled one clk after the start event, d2 just before iorq falls.
  task automatic io_rd(input logic [15:0] a, output logic [7:0] d1, output logic [7:0] d2);
    @(negedge clk);
    cpu_addr = a; iorq = 1'b1; rd = 1'b1; m1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d1 = cpu_din;
    @(posedge clk);
    @(negedge clk);
    d2 = cpu_din;
    iorq = 1'b0; rd = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_dout = d; iorq = 1'b1; wr = 1'b1; m1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    iorq = 1'b0; wr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    if (rx_q.size() < 16) rx_q.push_back(b);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic host_pop(output logic v, output logic [7:0] d);
    @(negedge clk);
    v = tx_valid; d = tx_data; tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] d1, d2;
    #23;
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL rst_irq got=%b want=0", irq); end
    n_checks++; if (cpu_din !== 8'hFF) begin n_errors++; $display("FAIL rst_din got=%02h want=ff", cpu_din); end
    n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL rst_txv got=%b want=0", tx_valid); end
    n_checks++; if (rx_ready !== 1'b1) begin n_errors++; $display("FAIL rst_rxr got=%b want=1", rx_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    io_rd(BASE + 16'd1, d1, d2);
    void'(m_read(2'd1));
    n_checks++; if (d1 !== 8'h0A) begin n_errors++; $display("FAIL rst_status got=%02h want=0a", d1); end
    io_rd(BASE + 16'd4, d1, d2);
    n_checks++; if (d1 !== 8'hFF) begin n_errors++; $display("FAIL nohit_rd got=%02h want=ff", d1); end
  endtask

  task automatic test_rx_path();
    logic [7:0] d1, d2, e;
    host_push(8'h41);
    host_push(8'h42);
    e = m_read(2'd0);
    io_rd(BASE, d1, d2);
    n_checks++; if (d1 !== 8'h41 || e !== 8'h41) begin n_errors++; $display("FAIL rx_first got=%02h want=41", d1); end
    n_checks++; if (d2 !== 8'h41) begin n_errors++; $display("FAIL rx_hold got=%02h want=41", d2); end
    e = m_read(2'd0);
    io_rd(BASE, d1, d2);
    n_checks++; if (d1 !== 8'h42) begin n_errors++; $display("FAIL rx_second got=%02h want=42", d1); end
    e = m_read(2'd0);
    io_rd(BASE, d1, d2);
    n_checks++; if (d1 !== 8'hFF) begin n_errors++; $display("FAIL rx_empty got=%02h want=ff", d1); end
    e = m_read(2'd1);
    io_rd(BASE + 16'd1, d1, d2);
    n_checks++; if (d1 !== e || d1[2] !== 1'b1) begin n_errors++; $display("FAIL rx_unf_set got=%02h want=%02h", d1, e); end
    e = m_read(2'd1);
    io_rd(BASE + 16'd1, d1, d2);
    n_checks++; if (d1 !== e || d1[2] !== 1'b0) begin n_errors++; $display("FAIL rx_unf_clr got=%02h want=%02h", d1, e); end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d1, d2, e, b;
    tx_ready = 1'b0;
    io_wr(BASE + 16'd2, 8'h80);
    m_write(2'd2, 8'h80);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      io_wr(BASE, b);
      m_write(2'd0, b);
    end
    n_checks++; if (tx_valid !== 1'b1) begin n_errors++; $display("FAIL tx_valid16 got=%b want=1", tx_valid); end
    e = m_read(2'd1);
    io_rd(BASE + 16'd1, d1, d2);
    n_checks++; if (d1 !== e || d1[1] !== 1'b0) begin n_errors++; $display("FAIL tx_full_st got=%02h want=%02h", d1, e); end
    io_wr(BASE, 8'h5A);
    m_write(2'd0, 8'h5A);
    e = m_read(2'd1);
    io_rd(BASE + 16'd1, d1, d2);
    n_checks++; if (d1 !== e || d1[4] !== 1'b1) begin n_errors++; $display("FAIL tx_ovf_st got=%02h want=%02h", d1, e); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && tx_q.size() > 0; i++) begin
      b = tx_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== b) begin
        n_errors++;
        $display("FAIL tx_drain[%0d] got=%b/%02h want=1/%02h", i, tx_valid, tx_data, b);
      end
      @(posedge clk);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL tx_drained got=%b want=0", tx_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_irq();
    logic [7:0] d1, d2, e;
    io_wr(BASE + 16'd2, 8'h01);
    m_write(2'd2, 8'h01);
    @(posedge clk); #1;
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_idle got=%b want=0", irq); end
    @(negedge clk);
    rx_data = 8'hC3; rx_valid = 1'b1;
    rx_q.push_back(8'hC3);
    @(posedge clk); #1;
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_lat got=%b want=0", irq); end
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_rise got=%b want=1", irq); end
    e = m_read(2'd0);
    io_rd(BASE, d1, d2);
    n_checks++; if (d1 !== e) begin n_errors++; $display("FAIL irq_rd got=%02h want=%02h", d1, e); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_fall got=%b want=0", irq); end
    io_wr(BASE + 16'd2, 8'h00);
    m_write(2'd2, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2, e, b;
    for (int i = 0; i < 3; i++) host_push(8'($urandom));
    b = 8'($urandom);
    e = rx_q.pop_front();
    rx_q.push_back(b);
    @(negedge clk);
    cpu_addr = BASE; iorq = 1'b1; rd = 1'b1; m1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d1 = cpu_din;
    iorq = 1'b0; rd = 1'b0; rx_data = b; rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (d1 !== e) begin n_errors++; $display("FAIL b2b_pop got=%02h want=%02h", d1, e); end
    for (int i = 0; i < 4; i++) begin
      e = m_read(2'd0);
      io_rd(BASE, d1, d2);
      n_checks++; if (d1 !== e) begin n_errors++; $display("FAIL b2b_rd[%0d] got=%02h want=%02h", i, d1, e); end
    end
    e = m_read(2'd1);
    io_rd(BASE + 16'd1, d1, d2);
    n_checks++; if (d1 !== e) begin n_errors++; $display("FAIL b2b_st got=%02h want=%02h", d1, e); end
  endtask

  task automatic test_flush();
    logic [7:0] d1, d2, e;
    tx_ready = 1'b0;
    host_push(8'h11);
    host_push(8'h22);
    io_wr(BASE, 8'h33); m_write(2'd0, 8'h33);
    io_wr(BASE, 8'h44); m_write(2'd0, 8'h44);
    io_wr(BASE + 16'd2, 8'h80);
    m_write(2'd2, 8'h80);
    n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL flush_txv got=%b want=0", tx_valid); end
    e = m_read(2'd2);
    io_rd(BASE + 16'd2, d1, d2);
    n_checks++; if (d1 !== 8'h00 || e !== 8'h00) begin n_errors++; $display("FAIL flush_ctrl got=%02h want=00", d1); end
    e = m_read(2'd1);
    io_rd(BASE + 16'd1, d1, d2);
    n_checks++; if (d1 !== e) begin n_errors++; $display("FAIL flush_st got=%02h want=%02h", d1, e); end
  endtask

  task automatic test_im2();
    logic [7:0] d1, d2, e, want;
    io_wr(BASE + 16'd2, 8'h82); m_write(2'd2, 8'h82);
    io_wr(BASE + 16'd3, 8'hE0); m_write(2'd3, 8'hE0);
    e = m_read(2'd3);
    io_rd(BASE + 16'd3, d1, d2);
    n_checks++; if (d1 !== e) begin n_errors++; $display("FAIL vec_rd got=%02h want=%02h", d1, e); end
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL im2_irq got=%b want=1", irq); end
`ifdef CPC_EXP_MAILBOX_IM2_EN
    want = 8'hE0;
`else
    want = 8'hFF;
`endif
    @(negedge clk);
    m1 = 1'b1; iorq = 1'b1; cpu_addr = 16'h00FF;
    @(posedge clk); #1;
    n_checks++; if (cpu_din !== want) begin n_errors++; $display("FAIL im2_ack got=%02h want=%02h", cpu_din, want); end
    @(negedge clk);
    m1 = 1'b0; iorq = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL im2_keep got=%b want=1", irq); end
    io_wr(BASE + 16'd2, 8'h00); m_write(2'd2, 8'h00);
    @(negedge clk);
    m1 = 1'b1; iorq = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cpu_din !== 8'hFF) begin n_errors++; $display("FAIL im2_noirq got=%02h want=ff", cpu_din); end
    @(negedge clk);
    m1 = 1'b0; iorq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d1, d2;
    host_push(8'hA5);
    io_wr(BASE + 16'd2, 8'h03); m_write(2'd2, 8'h03);
    @(negedge clk);
    cpu_addr = BASE; iorq = 1'b1; rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (cpu_din !== 8'hFF) begin n_errors++; $display("FAIL rstmid_din got=%02h want=ff", cpu_din); end
    @(negedge clk);
    iorq = 1'b0; rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    io_rd(BASE + 16'd1, d1, d2);
    void'(m_read(2'd1));
    n_checks++; if (d1 !== 8'h0A) begin n_errors++; $display("FAIL rstmid_st got=%02h want=0a", d1); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL rstmid_irq got=%b want=0", irq); end
  endtask

  task automatic test_random();
    logic [7:0] d1, d2, e, b;
    logic [1:0] off;
    logic       v;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          b = 8'($urandom);
          n_checks++;
          if (rx_ready !== (rx_q.size() < 16)) begin
            n_errors++;
            $display("FAIL rnd_rxr[%0d] got=%b want=%b", it, rx_ready, rx_q.size() < 16);
          end
          host_push(b);
        end
        1: begin
          host_pop(v, d1);
          n_checks++;
          if (v !== (tx_q.size() != 0) || (v && d1 !== tx_q[0])) begin
            n_errors++;
            $display("FAIL rnd_tx[%0d] got=%b/%02h want=%b", it, v, d1, tx_q.size() != 0);
          end
          if (tx_q.size() != 0) void'(tx_q.pop_front());
        end
        2, 3: begin
          off = 2'($urandom_range(0, 3));
          b = 8'($urandom);
          if (off == 2'd2 && $urandom_range(0, 7) != 0) b[7] = 1'b0;
          io_wr(BASE + {14'd0, off}, b);
          m_write(off, b);
        end
        default: begin
          off = 2'($urandom_range(0, 3));
          e = m_read(off);
          io_rd(BASE + {14'd0, off}, d1, d2);
          n_checks++;
          if (d1 !== e || d2 !== d1) begin
            n_errors++;
            $display("FAIL rnd_rd[%0d] off=%0d got=%02h/%02h want=%02h", it, off, d1, d2, e);
          end
        end
      endcase
      n_checks++;
      if (irq !== m_irq()) begin
        n_errors++;
        $display("FAIL rnd_irq[%0d] got=%b want=%b", it, irq, m_irq());
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    iorq = 1'b0; rd = 1'b0; wr = 1'b0; m1 = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    m_reset();
    test_reset();
    test_rx_path();
    test_tx_overflow();
    test_irq();
    test_back_to_back();
    test_flush();
    test_im2();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
